// File: rtl/ppu_vsq_stream.sv
// Post-processing stage: per-lane scale/bias/ReLU, one-group buffer, group max-magnitude,
// serial reciprocal, then rounded/saturated quantized output beats with the group scale.
module ppu_vsq_stream #(
  parameter int unsigned LANES = 16,
  parameter int unsigned IN_W  = 24,
  parameter int unsigned SCL_W = 8,
  parameter int unsigned ACC_W = 18,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned FRAC  = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [SCL_W-1:0]       cfg_scale,
  input  logic [SCL_W-1:0]       cfg_bias,
  input  logic [4:0]             cfg_shift,
  input  logic                   cfg_relu_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last,
  output logic [ACC_W-1:0]       out_recip,
  output logic [ACC_W-1:0]       vec_max,
  output logic                   busy
);
  localparam int unsigned P_W   = IN_W + SCL_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RC_W  = $clog2(ACC_W + 2);
  localparam int unsigned DVD_W = OUT_W + FRAC;
  localparam int unsigned DX_W  = (DVD_W > ACC_W) ? DVD_W : ACC_W + 1;
  localparam int unsigned M_W   = 2 * ACC_W + 2;
  localparam logic signed [P_W-1:0] P_HI = P_W'(2**(ACC_W-1) - 1);
  localparam logic signed [P_W-1:0] P_LO = ~P_HI;
  localparam logic signed [M_W-1:0] RND  = M_W'(2**(FRAC-1));

  typedef enum logic [1:0] {S_IDLE, S_INGEST, S_RECIP, S_EMIT} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q, rd_q;
  logic [RC_W-1:0]         rc_q;
  logic [SCL_W-1:0]        scale_q, bias_q;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic [ACC_W-1:0]        vmax_q, recip_q, quo_q, rem_q, dvd_q;
  logic                    sat_q;
  logic signed [ACC_W-1:0] mem_q [DEPTH][LANES];
  logic                    out_valid_q, out_last_q;
  logic [LANES*OUT_W-1:0]  out_data_q;

  logic                    in_fire, out_fire, load;
  logic [IDX_W-1:0]        wr_idx, rd_idx;

  assign in_ready  = !rst && (state_q == S_IDLE || state_q == S_INGEST);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_recip = recip_q;
  assign vec_max   = vmax_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign load      = (state_q == S_EMIT) && (rd_q < CNT_W'(DEPTH)) && (!out_valid_q || out_ready);
  assign wr_idx    = cnt_q[IDX_W-1:0];
  assign rd_idx    = rd_q[IDX_W-1:0];

  // The first beat of a group is processed with the live cfg ports, later beats with the latched copy.
  logic [SCL_W-1:0] scale_s, bias_s;
  logic [4:0]       shift_s;
  logic             relu_s;
  always_comb begin
    scale_s = scale_q;
    bias_s  = bias_q;
    shift_s = shift_q;
    relu_s  = relu_q;
    if (state_q == S_IDLE) begin
      scale_s = cfg_scale;
      bias_s  = cfg_bias;
      shift_s = cfg_shift;
      relu_s  = cfg_relu_en;
    end
  end

  logic signed [ACC_W-1:0] v_d [LANES];
  logic [ACC_W-1:0]        bmax_d;
  always_comb begin : lane_dp
    logic signed [P_W-1:0]   xe, se, be, p;
    logic signed [ACC_W-1:0] v;
    logic [ACC_W-1:0]        a;
    bmax_d = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      xe = P_W'($signed(in_data[l*IN_W +: IN_W]));
      se = P_W'($signed({1'b0, scale_s}));
      be = P_W'($signed(bias_s));
      p  = xe * se + be;
      if (relu_s && p < 0) p = '0;
      p = p >>> shift_s;
      if (p > P_HI)      v = P_HI[ACC_W-1:0];
      else if (p < P_LO) v = P_LO[ACC_W-1:0];
      else               v = p[ACC_W-1:0];
      v_d[l] = v;
      if (!v[ACC_W-1])                 a = $unsigned(v);
      else if (v == P_LO[ACC_W-1:0])   a = P_HI[ACC_W-1:0];
      else                             a = $unsigned(-v);
      if (a > bmax_d) bmax_d = a;
    end
  end

  logic [LANES*OUT_W-1:0] q_d;
  always_comb begin : emit_dp
    logic signed [M_W-1:0] ve, re, pr, qhi, qlo;
    q_d = '0;
    qhi = relu_q ? M_W'(2**OUT_W - 1) : M_W'(2**(OUT_W-1) - 1);
    qlo = relu_q ? '0 : -qhi;
    re  = M_W'($signed({1'b0, recip_q}));
    for (int unsigned l = 0; l < LANES; l++) begin
      ve = M_W'(mem_q[rd_idx][l]);
      pr = (ve * re + RND) >>> FRAC;
      if (pr > qhi)      pr = qhi;
      else if (pr < qlo) pr = qlo;
      q_d[l*OUT_W +: OUT_W] = pr[OUT_W-1:0];
    end
  end

  // Divider: overflow is decided up front (dividend high part >= divisor), so the remaining
  // ACC_W restoring steps only ever produce an in-range quotient.
  logic [DX_W-1:0]  dvd_full, dvd_hi;
  logic [ACC_W:0]   tr, tr_sub;
  logic             tr_ge;
  assign dvd_full = (relu_q ? DX_W'(2**OUT_W - 1) : DX_W'(2**(OUT_W-1) - 1)) << FRAC;
  assign dvd_hi   = dvd_full >> ACC_W;
  assign tr       = {rem_q, dvd_q[ACC_W-1]};
  assign tr_ge    = (tr >= {1'b0, vmax_q});
  assign tr_sub   = tr - {1'b0, vmax_q};

  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int unsigned l = 0; l < LANES; l++) mem_q[wr_idx][l] <= v_d[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      rc_q        <= '0;
      scale_q     <= '0;
      bias_q      <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      vmax_q      <= '0;
      recip_q     <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            scale_q <= cfg_scale;
            bias_q  <= cfg_bias;
            shift_q <= cfg_shift;
            relu_q  <= cfg_relu_en;
            vmax_q  <= bmax_d;
            cnt_q   <= CNT_W'(1);
            rc_q    <= '0;
            state_q <= (DEPTH == 1) ? S_RECIP : S_INGEST;
          end
        end
        S_INGEST: begin
          if (in_fire) begin
            if (bmax_d > vmax_q) vmax_q <= bmax_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DEPTH - 1)) state_q <= S_RECIP;
          end
        end
        S_RECIP: begin
          rc_q <= rc_q + 1'b1;
          if (rc_q == '0) begin
            rem_q <= dvd_hi[ACC_W-1:0];
            dvd_q <= dvd_full[ACC_W-1:0];
            quo_q <= '0;
            sat_q <= (vmax_q == '0) || (dvd_hi >= DX_W'(vmax_q));
          end else begin
            rem_q <= tr_ge ? tr_sub[ACC_W-1:0] : tr[ACC_W-1:0];
            dvd_q <= dvd_q << 1;
            quo_q <= {quo_q[ACC_W-2:0], tr_ge};
            if (rc_q == RC_W'(ACC_W)) begin
              recip_q <= sat_q ? '1 : {quo_q[ACC_W-2:0], tr_ge};
              rd_q    <= '0;
              state_q <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= q_d;
            out_last_q  <= (rd_q == CNT_W'(DEPTH - 1));
            rd_q        <= rd_q + 1'b1;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
          if (out_fire && out_last_q) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rc_q    <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ppu_vsq_stream.sv
// Scoreboard bench for ppu_vsq_stream: directed groups with hand-computed quantized beats.
module tb_ppu_vsq_stream;
  localparam int LANES = 16;
  localparam int IN_W  = 24;
  localparam int ACC_W = 18;
  localparam int OUT_W = 8;
  localparam int DEPTH = 16;
  localparam int LAT   = ACC_W + 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic [7:0]             cfg_scale, cfg_bias;
  logic [4:0]             cfg_shift;
  logic                   cfg_relu_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic                   out_last;
  logic [ACC_W-1:0]       out_recip, vec_max;
  logic                   busy;

  ppu_vsq_stream #(
    .LANES(16), .IN_W(24), .SCL_W(8), .ACC_W(18), .OUT_W(8), .DEPTH(16), .FRAC(13)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_scale(cfg_scale), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_recip(out_recip), .vec_max(vec_max), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    logic                   last;
    logic [ACC_W-1:0]       recip;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  logic [7:0] ramp_tab [DEPTH] = '{8'd8, 8'd16, 8'd24, 8'd32, 8'd40, 8'd48, 8'd56, 8'd64,
                                   8'd71, 8'd79, 8'd87, 8'd95, 8'd103, 8'd111, 8'd119, 8'd127};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("in_ready_during_emit", 128'(in_ready), 128'(0));
      if (out_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got data %0h, expected no beat", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", 128'(out_data), 128'(mon_e.data));
          chk("beat_last", 128'(out_last), 128'(mon_e.last));
          chk("beat_recip", 128'(out_recip), 128'(mon_e.recip));
        end
      end
    end
  end

  task automatic push_expect(input logic [7:0] q0, input logic [7:0] qe, input logic [7:0] qo,
                             input logic ramp, input logic [ACC_W-1:0] recip, input int nb);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      for (int l = 0; l < LANES; l++) begin
        if (ramp)        e.data[l*OUT_W +: OUT_W] = ramp_tab[b];
        else if (l == 0) e.data[l*OUT_W +: OUT_W] = q0;
        else if (l % 2)  e.data[l*OUT_W +: OUT_W] = qo;
        else             e.data[l*OUT_W +: OUT_W] = qe;
      end
      e.last  = (b == DEPTH - 1);
      e.recip = recip;
      exp_q.push_back(e);
    end
  endtask

  // cfg ports are scrambled after the first beat so that only the first-beat sample matters.
  task automatic send_group(input string nm, input logic relu, input logic [7:0] scl,
                            input logic [7:0] bias, input logic [4:0] sh,
                            input int x0, input int xe, input int xo, input logic ramp,
                            input logic hold);
    bit acc;
    for (int b = 0; b < DEPTH; b++) begin
      for (int l = 0; l < LANES; l++) begin
        int x;
        x = (l == 0) ? x0 : ((l % 2) ? xo : xe);
        if (ramp) x = x * (b + 1);
        in_data[l*IN_W +: IN_W] = IN_W'(x);
      end
      cfg_relu_en = (b == 0) ? relu : ~relu;
      cfg_scale   = (b == 0) ? scl  : ~scl;
      cfg_bias    = (b == 0) ? bias : ~bias;
      cfg_shift   = (b == 0) ? sh   : ~sh;
      in_valid    = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_in_accept: beat %0d not accepted, required accept", nm, b);
      end
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_first(input string nm, input logic [ACC_W-1:0] emax,
                            input logic [ACC_W-1:0] erecip);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(LAT));
    chk({nm, "_vec_max"}, 128'(vec_max), 128'(emax));
    chk({nm, "_recip"}, 128'(out_recip), 128'(erecip));
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        in_valid = 1'b0;
        if (!busy && !out_valid) done = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", nm, exp_q.size());
    end
  endtask

  task automatic wait_acc(input string nm, input int target);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (n_acc >= target) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_wait: accepted %0d beats, required %0d", nm, n_acc, target);
    end
  endtask

  task automatic run_simple(input string nm, input logic relu, input logic [7:0] scl,
                            input logic [7:0] bias, input logic [4:0] sh,
                            input int x0, input int xe, input int xo,
                            input logic [7:0] q0, input logic [7:0] qe, input logic [7:0] qo,
                            input logic [ACC_W-1:0] emax, input logic [ACC_W-1:0] erecip);
    push_expect(q0, qe, qo, 1'b0, erecip, DEPTH);
    send_group(nm, relu, scl, bias, sh, x0, xe, xo, 1'b0, 1'b0);
    wait_first(nm, emax, erecip);
    drain(nm);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    cfg_scale = '0;
    cfg_bias = '0;
    cfg_shift = '0;
    cfg_relu_en = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_vec_max", 128'(vec_max), 128'(0));
    chk("rst_recip", 128'(out_recip), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_simple("t1_relu_sat", 1'b1, 8'd2, 8'd0, 5'd0, 100, 100, 100,
               8'hFF, 8'hFF, 8'hFF, 18'd200, 18'd10444);
    run_simple("t2_zero", 1'b1, 8'd2, 8'd0, 5'd0, 0, 0, 0,
               8'h00, 8'h00, 8'h00, 18'd0, 18'h3FFFF);
    run_simple("t3_relu_alt", 1'b1, 8'd1, 8'd0, 5'd0, -50, -50, 50,
               8'h00, 8'h00, 8'hFF, 18'd50, 18'd41779);
    run_simple("t4_signed", 1'b0, 8'd1, 8'd0, 5'd0, -1000, 500, 500,
               8'h81, 8'h3F, 8'h3F, 18'd1000, 18'd1040);

    // backpressure: 5-cycle stall on beat 7 while in_valid stays high through EMIT
    base = n_acc;
    push_expect(8'h0, 8'h0, 8'h0, 1'b1, 18'd1016, DEPTH);
    send_group("t5_stall", 1'b0, 8'd1, 8'd0, 5'd0, 64, 64, 64, 1'b1, 1'b1);
    wait_first("t5_stall", 18'd1024, 18'd1016);
    wait_acc("t5_stall", base + 6);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("t5_stall");

    // reset during EMIT after three beats, then a clean rerun of the first group
    base = n_acc;
    push_expect(8'hFF, 8'hFF, 8'hFF, 1'b0, 18'd10444, 3);
    send_group("t6_pre", 1'b1, 8'd2, 8'd0, 5'd0, 100, 100, 100, 1'b0, 1'b0);
    wait_first("t6_pre", 18'd200, 18'd10444);
    wait_acc("t6_pre", base + 3);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_out_valid", 128'(out_valid), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(0));
    chk("t6_rst_vec_max", 128'(vec_max), 128'(0));
    chk("t6_rst_recip", 128'(out_recip), 128'(0));
    chk("t6_rst_queue", 128'(exp_q.size()), 128'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    run_simple("t6_rerun", 1'b1, 8'd2, 8'd0, 5'd0, 100, 100, 100,
               8'hFF, 8'hFF, 8'hFF, 18'd200, 18'd10444);

    // scale/bias/shift with negative floor rounding, then store saturation
    run_simple("t7_shift_bias", 1'b0, 8'd3, 8'hFA, 5'd2, 1000, -200, -200,
               8'h7F, 8'hE6, 8'hE6, 18'd748, 18'd1390);
    run_simple("t8_store_sat", 1'b0, 8'd3, 8'hFA, 5'd2, 8000000, -200, -200,
               8'h70, 8'h00, 8'h00, 18'd131071, 18'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
